mem_access_arbiter: RTL and testbench

MEM_ACCESS_ARBITER -- requirements
Module: mem_access_arbiter

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_access_arbiter_rr_pick2.sv | 18 +
 rtl/mem_access_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_access_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the two-requester BRAM access arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_IO  = 1'b1
    } req_id_e;

    // Command captured from the granted requester at grant time.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/mem_access_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie, the requester not granted last wins.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  req_id_e    last_grant_i,
    output req_id_e    grant_c_o
);

    // req_i[0] is the CPU, req_i[1] is the I/O port.
    always_comb begin
        grant_c_o = REQ_CPU;
        if (req_i[1] && (!req_i[0] || (last_grant_i == REQ_CPU))) begin
            grant_c_o = REQ_IO;
        end
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Arbitrates CPU and I/O requesters onto one BRAM port; one transaction at a time.
module mem_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned READ_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    input  logic              io_req,
    input  logic              io_we,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic [DATA_W-1:0] io_rdata,
    output logic              io_done,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout,
    output logic              busy
);

    localparam int unsigned CNT_W = 2;

    state_e            state_q, state_d;
    mem_cmd_t          cmd_q, cmd_d;
    req_id_e           owner_q, owner_d;
    req_id_e           last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] io_rdata_q, io_rdata_d;
    logic              bram_en_q, bram_en_d;
    logic              bram_we_q, bram_we_d;
    logic              cpu_done_q, cpu_done_d;
    logic              io_done_q, io_done_d;
    logic              busy_q, busy_d;

    req_id_e  pick_c;
    mem_cmd_t cpu_cmd_c, io_cmd_c;

    assign cpu_cmd_c = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
    assign io_cmd_c  = '{we: io_we, addr: io_addr, wdata: io_wdata};

    rr_pick2 u_pick (
        .req_i       ({io_req, cpu_req}),
        .last_grant_i(last_q),
        .grant_c_o   (pick_c)
    );

    // Next state plus next values of every registered output.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        io_rdata_d  = io_rdata_q;

        case (state_q)
            IDLE: begin
                if (cpu_req || io_req) begin
                    owner_d = pick_c;
                    last_d  = pick_c;
                    cmd_d   = (pick_c == REQ_CPU) ? cpu_cmd_c : io_cmd_c;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_W'(READ_LAT - 1);
                state_d = cmd_q.we ? DONE : WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    if (owner_q == REQ_CPU) begin
                        cpu_rdata_d = bram_dout;
                    end else begin
                        io_rdata_d = bram_dout;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        bram_en_d  = (state_d == ISSUE);
        bram_we_d  = (state_d == ISSUE) && cmd_d.we;
        cpu_done_d = (state_d == DONE) && (owner_d == REQ_CPU);
        io_done_d  = (state_d == DONE) && (owner_d == REQ_IO);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            owner_q     <= REQ_CPU;
            last_q      <= REQ_IO;
            cnt_q       <= '0;
            cpu_rdata_q <= '0;
            io_rdata_q  <= '0;
            bram_en_q   <= 1'b0;
            bram_we_q   <= 1'b0;
            cpu_done_q  <= 1'b0;
            io_done_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            io_rdata_q  <= io_rdata_d;
            bram_en_q   <= bram_en_d;
            bram_we_q   <= bram_we_d;
            cpu_done_q  <= cpu_done_d;
            io_done_q   <= io_done_d;
            busy_q      <= busy_d;
        end
    end

    // BRAM address/data come straight from the command latched at grant.
    assign bram_addr = cmd_q.addr;
    assign bram_din  = cmd_q.wdata;
    assign bram_en   = bram_en_q;
    assign bram_we   = bram_we_q;
    assign cpu_rdata = cpu_rdata_q;
    assign io_rdata  = io_rdata_q;
    assign cpu_done  = cpu_done_q;
    assign io_done   = io_done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench: READ_LAT=2 and READ_LAT=3 arbiters driven side by side, checked against a timeline model.
module tb_mem_access_arbiter;

    localparam int NL = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req [NL];
    logic        io_req  [NL];
    logic        cpu_we, io_we;
    logic [15:0] cpu_addr, cpu_wdata, io_addr, io_wdata;
    logic [15:0] cpu_rdata [NL];
    logic [15:0] io_rdata  [NL];
    logic [15:0] bram_addr [NL];
    logic [15:0] bram_din  [NL];
    logic [15:0] bram_dout [NL];
    logic        cpu_done  [NL];
    logic        io_done   [NL];
    logic        bram_en   [NL];
    logic        bram_we   [NL];
    logic        busy      [NL];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NL; g++) begin : lane
        localparam int unsigned LAT = 2 + g;
        logic [15:0] bmem [256] = '{default: 16'h0000};
        logic [15:0] pipe [4];

        mem_access_arbiter #(.READ_LAT(LAT)) dut (
            .clk      (clk),
            .reset    (reset),
            .cpu_req  (cpu_req[g]),
            .cpu_we   (cpu_we),
            .cpu_addr (cpu_addr),
            .cpu_wdata(cpu_wdata),
            .cpu_rdata(cpu_rdata[g]),
            .cpu_done (cpu_done[g]),
            .io_req   (io_req[g]),
            .io_we    (io_we),
            .io_addr  (io_addr),
            .io_wdata (io_wdata),
            .io_rdata (io_rdata[g]),
            .io_done  (io_done[g]),
            .bram_en  (bram_en[g]),
            .bram_we  (bram_we[g]),
            .bram_addr(bram_addr[g]),
            .bram_din (bram_din[g]),
            .bram_dout(bram_dout[g]),
            .busy     (busy[g])
        );

        // BRAM with LAT cycles from address-sampling edge to valid dout.
        always @(posedge clk) begin
            if (bram_en[g]) begin
                if (bram_we[g]) bmem[bram_addr[g][7:0]] <= bram_din[g];
                else            pipe[0] <= bmem[bram_addr[g][7:0]];
            end
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end
        assign bram_dout[g] = pipe[LAT-1];
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit armed = 0;
    int lat [NL];

    // Timeline model: when each accepted request issues, finishes, and frees the port.
    bit          act    [NL];
    int          s_c    [NL];
    int          td     [NL];
    int          free_c [NL];
    bit          mwe    [NL];
    logic [15:0] maddr  [NL];
    logic [15:0] mwd    [NL];
    int          owner  [NL];
    int          lastg  [NL];
    logic [15:0] pend   [NL];
    logic [15:0] exp_crd[NL];
    logic [15:0] exp_ird[NL];
    logic [15:0] mmem   [NL][256];

    int cdone_cyc[NL], idone_cyc[NL], cdone_cnt[NL], idone_cnt[NL], igap[NL];
    bit drop_c[NL], drop_i[NL];
    bit hold_io = 0;

    task automatic chk(input string nm, input int l, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s lane%0d: got 0x%0h want 0x%0h (cycle %0d)", nm, l, got, want, cyc);
        end
    endtask

    task automatic step();
        int n;
        n = cyc;
        for (int l = 0; l < NL; l++) begin
            bit iss;
            bit fin;
            iss = act[l] && (n == s_c[l] + 1);
            fin = act[l] && (n == td[l]);
            if (fin && !mwe[l]) begin
                if (owner[l] == 0) exp_crd[l] = pend[l];
                else               exp_ird[l] = pend[l];
            end
            if (armed) begin
                chk("busy", l, busy[l], act[l] && (n > s_c[l]));
                chk("bram_en", l, bram_en[l], iss);
                chk("bram_we", l, bram_we[l], iss && mwe[l]);
                if (iss) begin
                    chk("bram_addr", l, bram_addr[l], maddr[l]);
                    if (mwe[l]) chk("bram_din", l, bram_din[l], mwd[l]);
                end
                chk("cpu_done", l, cpu_done[l], fin && (owner[l] == 0));
                chk("io_done", l, io_done[l], fin && (owner[l] == 1));
                chk("cpu_rdata", l, cpu_rdata[l], exp_crd[l]);
                chk("io_rdata", l, io_rdata[l], exp_ird[l]);
            end
            if (cpu_done[l] === 1'b1) begin
                cdone_cyc[l] = n;
                cdone_cnt[l]++;
                drop_c[l] = 1'b1;
            end
            if (io_done[l] === 1'b1) begin
                igap[l] = n - idone_cyc[l];
                idone_cyc[l] = n;
                idone_cnt[l]++;
                if (!hold_io) drop_i[l] = 1'b1;
            end
            if (iss) begin
                if (mwe[l]) mmem[l][maddr[l][7:0]] = mwd[l];
                else        pend[l] = mmem[l][maddr[l][7:0]];
            end
            if (fin) act[l] = 1'b0;
            if (reset) begin
                act[l]     = 1'b0;
                free_c[l]  = n + 1;
                lastg[l]   = 1;
                exp_crd[l] = 16'h0000;
                exp_ird[l] = 16'h0000;
            end else if (!act[l] && (n >= free_c[l]) && (cpu_req[l] || io_req[l])) begin
                if (cpu_req[l] && io_req[l]) owner[l] = (lastg[l] == 0) ? 1 : 0;
                else                         owner[l] = io_req[l] ? 1 : 0;
                lastg[l]  = owner[l];
                mwe[l]    = (owner[l] == 1) ? io_we : cpu_we;
                maddr[l]  = (owner[l] == 1) ? io_addr : cpu_addr;
                mwd[l]    = (owner[l] == 1) ? io_wdata : cpu_wdata;
                s_c[l]    = n;
                td[l]     = n + 2 + (mwe[l] ? 0 : lat[l]);
                free_c[l] = td[l] + 1;
                act[l]    = 1'b1;
            end
        end
        if (reset) armed = 1'b1;
    endtask

    task automatic tick();
        @(negedge clk);
        step();
        @(posedge clk);
        cyc++;
        #1;
        for (int l = 0; l < NL; l++) begin
            if (drop_c[l]) begin cpu_req[l] = 1'b0; drop_c[l] = 1'b0; end
            if (drop_i[l]) begin io_req[l] = 1'b0; drop_i[l] = 1'b0; end
        end
    endtask

    task automatic wait_idle(input int max_c);
        int k;
        bit ok;
        k = 0;
        ok = 1'b0;
        while (!ok && k < max_c) begin
            tick();
            k++;
            ok = 1'b1;
            for (int l = 0; l < NL; l++)
                if (cpu_req[l] || io_req[l] || busy[l] !== 1'b0) ok = 1'b0;
        end
        chk("idle_reached", 0, ok, 1);
    endtask

    task automatic post_cpu(input logic we, input logic [15:0] a, input logic [15:0] d);
        cpu_we = we; cpu_addr = a; cpu_wdata = d;
        for (int l = 0; l < NL; l++) cpu_req[l] = 1'b1;
    endtask

    task automatic post_io(input logic we, input logic [15:0] a, input logic [15:0] d);
        io_we = we; io_addr = a; io_wdata = d;
        for (int l = 0; l < NL; l++) io_req[l] = 1'b1;
    endtask

    initial begin
        int c0;
        int saved [NL];
        reset = 1'b1;
        cpu_we = 0; io_we = 0;
        cpu_addr = 0; cpu_wdata = 0; io_addr = 0; io_wdata = 0;
        for (int l = 0; l < NL; l++) begin
            cpu_req[l] = 0; io_req[l] = 0; act[l] = 0; s_c[l] = 0; td[l] = 0; free_c[l] = 0;
            mwe[l] = 0; maddr[l] = 0; mwd[l] = 0; owner[l] = 0; lastg[l] = 1; pend[l] = 0;
            exp_crd[l] = 0; exp_ird[l] = 0; cdone_cyc[l] = 0; idone_cyc[l] = 0;
            cdone_cnt[l] = 0; idone_cnt[l] = 0; igap[l] = 0; drop_c[l] = 0; drop_i[l] = 0;
            lat[l] = 2 + l;
            for (int a = 0; a < 256; a++) mmem[l][a] = 16'h0000;
        end
        repeat (3) tick();
        reset = 1'b0;
        tick();
        for (int l = 0; l < NL; l++) begin
            chk("rst_busy", l, busy[l], 0);
            chk("rst_bram_en", l, bram_en[l], 0);
            chk("rst_cpu_rdata", l, cpu_rdata[l], 16'h0000);
            chk("rst_io_rdata", l, io_rdata[l], 16'h0000);
        end

        // CPU write then read-back of 0x0010.
        c0 = cyc; post_cpu(1'b1, 16'h0010, 16'hBEEF); wait_idle(30);
        for (int l = 0; l < NL; l++) chk("wr_latency", l, cdone_cyc[l] - c0, 2);
        c0 = cyc; post_cpu(1'b0, 16'h0010, 16'h0000); wait_idle(30);
        for (int l = 0; l < NL; l++) begin
            chk("rd_latency", l, cdone_cyc[l] - c0, (l == 0) ? 4 : 5);
            chk("rd_data", l, cpu_rdata[l], 16'hBEEF);
            chk("no_io_done", l, idone_cnt[l], 0);
        end

        // IO writes 0x1234 to 0x0020; reset so the CPU wins the next tie.
        post_io(1'b1, 16'h0020, 16'h1234); wait_idle(30);
        reset = 1'b1; tick(); reset = 1'b0; tick();
        c0 = cyc; post_cpu(1'b0, 16'h0010, 16'h0); post_io(1'b0, 16'h0020, 16'h0); wait_idle(60);
        for (int l = 0; l < NL; l++) begin
            chk("tie1_cpu_lat", l, cdone_cyc[l] - c0, (l == 0) ? 4 : 5);
            chk("tie1_io_lat", l, idone_cyc[l] - c0, (l == 0) ? 9 : 11);
            chk("tie1_cpu_data", l, cpu_rdata[l], 16'hBEEF);
            chk("tie1_io_data", l, io_rdata[l], 16'h1234);
        end

        // After a CPU-only grant, a simultaneous burst goes to IO first.
        post_cpu(1'b1, 16'h0030, 16'h5555); wait_idle(30);
        c0 = cyc; post_cpu(1'b0, 16'h0030, 16'h0); post_io(1'b0, 16'h0010, 16'h0); wait_idle(60);
        for (int l = 0; l < NL; l++) begin
            chk("tie2_io_lat", l, idone_cyc[l] - c0, (l == 0) ? 4 : 5);
            chk("tie2_cpu_lat", l, cdone_cyc[l] - c0, (l == 0) ? 9 : 11);
            chk("tie2_cpu_data", l, cpu_rdata[l], 16'h5555);
            chk("tie2_io_data", l, io_rdata[l], 16'hBEEF);
        end

        // Address moves to 0x0020 mid-read; data must still come from 0x0010.
        c0 = cyc; post_cpu(1'b0, 16'h0010, 16'h0);
        repeat (3) tick();
        cpu_addr = 16'h0020;
        wait_idle(30);
        for (int l = 0; l < NL; l++) chk("addr_hold_data", l, cpu_rdata[l], 16'hBEEF);

        // Reset in WAIT aborts the read; a fresh read completes.
        for (int l = 0; l < NL; l++) saved[l] = cdone_cnt[l];
        post_cpu(1'b0, 16'h0020, 16'h0);
        repeat (2) tick();
        reset = 1'b1;
        for (int l = 0; l < NL; l++) cpu_req[l] = 1'b0;
        tick();
        reset = 1'b0;
        for (int l = 0; l < NL; l++) begin
            chk("abort_busy", l, busy[l], 0);
            chk("abort_no_done", l, cdone_cnt[l], saved[l]);
            chk("abort_rdata", l, cpu_rdata[l], 16'h0000);
        end
        tick();
        c0 = cyc; post_cpu(1'b0, 16'h0020, 16'h0); wait_idle(30);
        for (int l = 0; l < NL; l++) begin
            chk("fresh_latency", l, cdone_cyc[l] - c0, (l == 0) ? 4 : 5);
            chk("fresh_data", l, cpu_rdata[l], 16'h1234);
        end

        // Held io_req: back-to-back reads, one per read-latency+3 cycles.
        hold_io = 1'b1;
        post_io(1'b0, 16'h0020, 16'h0);
        repeat (14) tick();
        for (int l = 0; l < NL; l++) chk("held_gap", l, igap[l], (l == 0) ? 5 : 6);
        hold_io = 1'b0;
        wait_idle(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
